// File: rtl/fun_param.sv
// fun_param: iterative y = floor(sqrt(a + floor(cbrt(b)))) with sqrt-only and cbrt-only modes,
// using digit-by-digit cube root (3 bits per two cycles) and square root (2 bits per cycle).
module fun_param #(
    parameter int WIDTH      = 8,
    parameter int CBRT_STEPS = (WIDTH + 2) / 3,
    parameter int SQRT_STEPS = (WIDTH + 2) / 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       mode_bi,
    input  logic [WIDTH-1:0] a_bi,
    input  logic [WIDTH-1:0] b_bi,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] y_bo
);
    // Wide enough that (3r(r+1)+1) << s never truncates for any legal WIDTH.
    localparam int TW = 3 * CBRT_STEPS + 3;
    localparam int SW = 2 * SQRT_STEPS;

    typedef enum logic [2:0] {IDLE, CBRT_MUL, CBRT_CMP, SQRT_STEP, DONE} state_t;

    state_t           state;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] c_rem;
    logic [WIDTH-1:0] c_root;
    logic [TW-1:0]    t;
    logic [SW-1:0]    s_rem;
    logic [SW-1:0]    s_root;
    logic [5:0]       cnt;

    logic [TW-1:0]    r2;
    logic [TW-1:0]    t_next;
    logic             c_ge;
    logic [WIDTH-1:0] root_next;
    logic [WIDTH:0]   rad;
    logic [SW-1:0]    one;
    logic [SW-1:0]    trial;
    logic             s_ge;
    logic [SW-1:0]    s_rem_next;
    logic [SW-1:0]    s_root_next;

    always_comb begin
        r2          = TW'(c_root) << 1;
        t_next      = (TW'(3) * r2 * (r2 + TW'(1)) + TW'(1)) << (3 * cnt);
        c_ge        = TW'(c_rem) >= t;
        root_next   = c_ge ? c_root + WIDTH'(1) : c_root;
        rad         = {1'b0, a_q} + (WIDTH + 1)'(root_next);
        one         = SW'(1) << (2 * cnt);
        trial       = s_root + one;
        s_ge        = s_rem >= trial;
        s_rem_next  = s_ge ? s_rem - trial : s_rem;
        s_root_next = s_ge ? (s_root >> 1) + one : s_root >> 1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            mode   <= '0;
            a_q    <= '0;
            c_rem  <= '0;
            c_root <= '0;
            t      <= '0;
            s_rem  <= '0;
            s_root <= '0;
            cnt    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            y_bo   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        a_q    <= a_bi;
                        mode   <= mode_bi;
                        busy_o <= 1'b1;
                        c_rem  <= b_bi;
                        c_root <= '0;
                        s_rem  <= SW'(a_bi);
                        s_root <= '0;
                        cnt    <= (mode_bi == 2'b01) ? 6'(SQRT_STEPS - 1) : 6'(CBRT_STEPS - 1);
                        state  <= (mode_bi == 2'b01) ? SQRT_STEP : CBRT_MUL;
                    end
                end
                CBRT_MUL: begin
                    c_root <= r2[WIDTH-1:0];
                    t      <= t_next;
                    state  <= CBRT_CMP;
                end
                CBRT_CMP: begin
                    if (c_ge) c_rem <= c_rem - t[WIDTH-1:0];
                    c_root <= root_next;
                    if (cnt != 6'd0) begin
                        cnt   <= cnt - 6'd1;
                        state <= CBRT_MUL;
                    end else if (mode == 2'b10) begin
                        y_bo   <= root_next;
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else begin
                        s_rem  <= SW'(rad);
                        s_root <= '0;
                        cnt    <= 6'(SQRT_STEPS - 1);
                        state  <= SQRT_STEP;
                    end
                end
                SQRT_STEP: begin
                    s_rem  <= s_rem_next;
                    s_root <= s_root_next;
                    if (cnt != 6'd0) begin
                        cnt <= cnt - 6'd1;
                    end else begin
                        y_bo   <= s_root_next[WIDTH-1:0];
                        done_o <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fun_param.sv
// tb_fun_param: table vectors, hand sequences and randomized ops against an arithmetic root model.
module tb_fun_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done;
    logic [7:0] y;

    logic        s16 = 1'b0, busy16, done16;
    logic [1:0]  m16 = '0;
    logic [15:0] a16 = '0, b16 = '0, y16;
    logic        s5 = 1'b0, busy5, done5;
    logic [1:0]  m5 = '0;
    logic [4:0]  a5 = '0, b5 = '0, y5;

    int checks = 0;
    int errors = 0;

    fun_param dut (.clk_i(clk), .rst_i(rst), .start_i(start), .mode_bi(mode), .a_bi(a), .b_bi(b),
                   .busy_o(busy), .done_o(done), .y_bo(y));
    fun_param #(.WIDTH(16)) dut16 (.clk_i(clk), .rst_i(rst), .start_i(s16), .mode_bi(m16), .a_bi(a16),
                   .b_bi(b16), .busy_o(busy16), .done_o(done16), .y_bo(y16));
    fun_param #(.WIDTH(5)) dut5 (.clk_i(clk), .rst_i(rst), .start_i(s5), .mode_bi(m5), .a_bi(a5),
                   .b_bi(b5), .busy_o(busy5), .done_o(done5), .y_bo(y5));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    function automatic longint icbrt(input longint v);
        longint j = 0;
        while ((j + 1) * (j + 1) * (j + 1) <= v) j++;
        return j;
    endfunction

    function automatic longint isqrt(input longint v);
        longint j = 0;
        while ((j + 1) * (j + 1) <= v) j++;
        return j;
    endfunction

    function automatic longint ref_y(input int m, input longint av, input longint bv);
        if (m == 1) return isqrt(av);
        if (m == 2) return icbrt(bv);
        return isqrt(av + icbrt(bv));
    endfunction

    function automatic int ref_busy(input int m);
        return (m == 1) ? 6 : (m == 2) ? 7 : 12;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic op8(input logic [1:0] m, input logic [7:0] av, input logic [7:0] bv,
                       output logic [7:0] yv, output int nb, output int nd, output int last_done);
        @(negedge clk);
        mode = m; a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0; nd = 0; last_done = -1;
        while (busy && nb < 100) begin
            nb++;
            if (done) begin
                nd++;
                last_done = nb;
            end
            @(negedge clk);
        end
        yv = y;
    endtask

    task automatic run_check(input string tag, input logic [1:0] m, input logic [7:0] av,
                             input logic [7:0] bv, input longint ey, input int eb);
        logic [7:0] yv;
        int nb, nd, ld;
        op8(m, av, bv, yv, nb, nd, ld);
        chk({tag, "_y"}, yv, ey);
        chk({tag, "_busy"}, nb, eb);
        chk({tag, "_done_count"}, nd, 1);
        chk({tag, "_done_pos"}, ld, eb);
    endtask

    typedef struct {
        logic [1:0] m;
        int         av;
        int         bv;
        int         ey;
        int         eb;
    } vec_t;

    vec_t vecs[6];
    logic bz[26], dz[26];
    logic [7:0] yz[26];

    initial begin
        vecs[0] = '{2'd0, 16, 64, 4, 12};
        vecs[1] = '{2'd0, 255, 255, 16, 12};
        vecs[2] = '{2'd0, 0, 0, 0, 12};
        vecs[3] = '{2'd1, 200, 0, 14, 6};
        vecs[4] = '{2'd2, 0, 200, 5, 7};
        vecs[5] = '{2'd3, 3, 1, 2, 12};

        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_y", y, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            run_check("vec", vecs[i].m, 8'(vecs[i].av), 8'(vecs[i].bv), vecs[i].ey, vecs[i].eb);

        for (int av = 0; av <= 16; av++)
            for (int j = 0; j <= 4; j++)
                run_check("cube_grid", 2'd0, 8'(av), 8'(j * j * j), isqrt(av + j), 12);

        for (int i = 0; i < 1500; i++) begin
            int m = int'($urandom_range(0, 3));
            int av = int'($urandom_range(0, 255));
            int bv = int'($urandom_range(0, 255));
            run_check("rand", 2'(m), 8'(av), 8'(bv), ref_y(m, av, bv), ref_busy(m));
        end

        // start held high; operands change mid-operation and must not affect the first result
        @(negedge clk);
        mode = 2'd0; a = 8'd16; b = 8'd64; start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 26; i++) begin
            if (i == 3) begin
                a = 8'd255; b = 8'd255;
            end
            bz[i] = busy; dz[i] = done; yz[i] = y;
            if (i == 25) start = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < 26; i++) begin
            chk($sformatf("held_busy[%0d]", i), bz[i], (i == 12 || i == 25) ? 0 : 1);
            chk($sformatf("held_done[%0d]", i), dz[i], (i == 11 || i == 24) ? 1 : 0);
        end
        chk("held_y_first", yz[11], 4);
        chk("held_y_second", yz[24], 16);
        chk("held_idle_after", busy, 0);

        // async reset in the middle of CBRT_CMP
        @(negedge clk);
        mode = 2'd0; a = 8'd255; b = 8'd255; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_y", y, 16);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_y", y, 0);
        @(negedge clk);
        rst = 1'b0;
        run_check("post_rst", 2'd0, 8'd16, 8'd64, 4, 12);

        begin
            int n = 0;
            @(negedge clk);
            s16 = 1'b1; m16 = 2'd0; a16 = 16'hFFFF; b16 = 16'hFFFF;
            @(negedge clk);
            s16 = 1'b0;
            while (busy16 && n < 200) begin
                n++;
                @(negedge clk);
            end
            chk("w16_y", y16, 256);
            chk("w16_busy", n, 22);
            n = 0;
            s5 = 1'b1; m5 = 2'd0; a5 = 5'd31; b5 = 5'd27;
            @(negedge clk);
            s5 = 1'b0;
            while (busy5 && n < 200) begin
                n++;
                @(negedge clk);
            end
            chk("w5_y", y5, 5);
            chk("w5_busy", n, 8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
